idli_sqi_rsp_m: RTL and testbench

IDLI_SQI_RSP_M -- requirements
Module: idli_sqi_rsp_m

---
 rtl/idli_sqi_rsp_m.sv | 155 +++++++++++++++
 tb/tb_idli_sqi_rsp_m.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_rsp_m.sv
// SQI (quad-SPI) responder: decodes READ/WRITE commands from the initiator and
// streams 16-bit words to/from a backing store with auto-incrementing word address.
module idli_sqi_rsp_m (
    input  logic        i_srsp_gck,
    input  logic        i_srsp_rst_n,
    input  logic        i_srsp_cs_n,
    input  logic [3:0]  i_srsp_sio,
    output logic [3:0]  o_srsp_sio,
    output logic        o_srsp_sio_oe,
    output logic [15:0] o_srsp_mem_addr,
    output logic        o_srsp_mem_rd,
    input  logic [15:0] i_srsp_mem_rdata,
    output logic        o_srsp_mem_wr,
    output logic [15:0] o_srsp_mem_wdata
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned NW = 4;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Nibble-counter values at which the per-word events fall (counter = cycle mod 4)
    localparam logic [1:0] CNT_ADDR_LAST = 2'd1;
    localparam logic [1:0] CNT_RD_STROBE = 2'd2;
    localparam logic [1:0] CNT_RD_RELOAD = 2'd3;
    localparam logic [1:0] CNT_WR_STROBE = 2'd1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

    state_t          state, state_d;
    logic [1:0]      cnt, cnt_d;
    logic [AW-1:0]   addr, addr_d;
    logic [DW-1:0]   tx, tx_d;
    logic [DW-1:0]   rx, rx_d;
    logic [NW-1:0]   cmd_hi, cmd_hi_d;
    logic            is_rd, is_rd_d;

    // State and datapath registers
    always_ff @(posedge i_srsp_gck or negedge i_srsp_rst_n) begin
        if (!i_srsp_rst_n) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            addr   <= '0;
            tx     <= '0;
            rx     <= '0;
            cmd_hi <= '0;
            is_rd  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            addr   <= addr_d;
            tx     <= tx_d;
            rx     <= rx_d;
            cmd_hi <= cmd_hi_d;
            is_rd  <= is_rd_d;
        end
    end

    // Next-state, datapath updates and memory/SIO outputs
    always_comb begin
        state_d          = state;
        cnt_d            = 2'(cnt + 2'd1);
        addr_d           = addr;
        tx_d             = tx;
        rx_d             = rx;
        cmd_hi_d         = cmd_hi;
        is_rd_d          = is_rd;
        o_srsp_sio       = 4'h0;
        o_srsp_sio_oe    = 1'b0;
        o_srsp_mem_addr  = addr;
        o_srsp_mem_rd    = 1'b0;
        o_srsp_mem_wr    = 1'b0;
        o_srsp_mem_wdata = '0;

        unique case (state)
            IDLE: begin
                cmd_hi_d = i_srsp_sio;
                state_d  = CMD;
            end
            CMD: begin
                if ({cmd_hi, i_srsp_sio} == CMD_READ) begin
                    is_rd_d = 1'b1;
                    state_d = ADDR;
                end else if ({cmd_hi, i_srsp_sio} == CMD_WRITE) begin
                    is_rd_d = 1'b0;
                    state_d = ADDR;
                end else begin
                    state_d = IGNORE;
                end
            end
            ADDR: begin
                addr_d = {addr[AW-5:0], i_srsp_sio};
                if (cnt == CNT_ADDR_LAST) begin
                    state_d = is_rd ? DUMMY : WDATA;
                end
            end
            DUMMY: begin
                o_srsp_mem_rd = (cnt == CNT_RD_STROBE);
                if (cnt == CNT_RD_RELOAD) begin
                    tx_d    = i_srsp_mem_rdata;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                // Prefetch of the next word is issued two nibbles before it is needed
                o_srsp_sio_oe   = 1'b1;
                o_srsp_sio      = tx[DW-1:DW-4];
                o_srsp_mem_addr = AW'(addr + AW'(1));
                tx_d            = {tx[DW-5:0], 4'h0};
                if (cnt == CNT_RD_STROBE) begin
                    o_srsp_mem_rd = 1'b1;
                    addr_d        = AW'(addr + AW'(1));
                end
                if (cnt == CNT_RD_RELOAD) begin
                    tx_d = i_srsp_mem_rdata;
                end
            end
            WDATA: begin
                rx_d = {rx[DW-5:0], i_srsp_sio};
                if (cnt == CNT_WR_STROBE) begin
                    o_srsp_mem_wr    = 1'b1;
                    o_srsp_mem_wdata = {rx[DW-5:0], i_srsp_sio};
                    addr_d           = AW'(addr + AW'(1));
                end
            end
            IGNORE: begin
                state_d = IGNORE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Deselect aborts everything and suppresses any strobe due this cycle
        if (i_srsp_cs_n) begin
            state_d          = IDLE;
            cnt_d            = 2'd0;
            addr_d           = addr;
            o_srsp_mem_rd    = 1'b0;
            o_srsp_mem_wr    = 1'b0;
            o_srsp_mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_idli_sqi_rsp_m.sv
// Randomized bench for idli_sqi_rsp_m: drives SQI transactions and compares every
// cycle against a transaction-level model of the READ/WRITE protocol.
module tb_idli_sqi_rsp_m;

    logic        clk;
    logic        rst_n;
    logic        cs_n;
    logic [3:0]  sio_in;
    logic [3:0]  sio_out;
    logic        sio_oe;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_wr;
    logic [15:0] mem_wdata;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    idli_sqi_rsp_m dut (
        .i_srsp_gck       (clk),
        .i_srsp_rst_n     (rst_n),
        .i_srsp_cs_n      (cs_n),
        .i_srsp_sio       (sio_in),
        .o_srsp_sio       (sio_out),
        .o_srsp_sio_oe    (sio_oe),
        .o_srsp_mem_addr  (mem_addr),
        .o_srsp_mem_rd    (mem_rd),
        .i_srsp_mem_rdata (mem_rdata),
        .o_srsp_mem_wr    (mem_wr),
        .o_srsp_mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing store with one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_oe"}, 16'(sio_oe), 16'h0);
        chk({tag, "_sio"}, 16'(sio_out), 16'h0);
        chk({tag, "_rd"}, 16'(mem_rd), 16'h0);
        chk({tag, "_wr"}, 16'(mem_wr), 16'h0);
        chk({tag, "_addr"}, mem_addr, 16'h0);
        chk({tag, "_wdata"}, mem_wdata, 16'h0);
    endtask

    // One transaction: cs_n low for ncyc cycles, then one deselect cycle and one idle cycle.
    // rst_at >= 0 pulses reset during that cycle and abandons the transaction.
    task automatic run_txn(input logic [7:0] cmd, input logic [15:0] a, input logic [63:0] wd,
                           input int ncyc, input int rst_at);
        bit          is_r, is_w, exp_oe, exp_rd, exp_wr;
        logic [3:0]  exp_sio;
        logic [15:0] ea, ew;
        is_r = (cmd == 8'h03);
        is_w = (cmd == 8'h02);
        for (int k = 0; k <= ncyc + 1; k++) begin
            @(posedge clk);
            #1;
            cs_n = (k < ncyc) ? 1'b0 : 1'b1;
            if (k < 2)                    sio_in = 4'(cmd >> (4 * (1 - k)));
            else if (k < 6)               sio_in = 4'(a >> (4 * (5 - k)));
            else if (is_w && k - 6 < 16)  sio_in = 4'(wd >> (4 * (15 - (k - 6))));
            else                          sio_in = 4'($urandom);
            @(negedge clk);
            if (k < ncyc) begin
                exp_oe  = is_r && k >= 8;
                exp_sio = 4'h0;
                if (exp_oe) begin
                    ew      = mem[16'(int'(a) + (k - 8) / 4)];
                    exp_sio = 4'(ew >> (4 * (3 - (k - 8) % 4)));
                end
                exp_rd = is_r && (k == 6 || (k >= 10 && (k - 10) % 4 == 0));
                exp_wr = is_w && k >= 9 && (k - 9) % 4 == 0;
                chk($sformatf("c%0d_oe", k), 16'(sio_oe), 16'(exp_oe));
                chk($sformatf("c%0d_sio", k), 16'(sio_out), 16'(exp_sio));
                chk($sformatf("c%0d_rd", k), 16'(mem_rd), 16'(exp_rd));
                chk($sformatf("c%0d_wr", k), 16'(mem_wr), 16'(exp_wr));
                if (exp_rd) begin
                    ea = 16'(int'(a) + (k - 6) / 4);
                    chk($sformatf("c%0d_rd_addr", k), mem_addr, ea);
                end
                if (exp_wr) begin
                    ea = 16'(int'(a) + (k - 9) / 4);
                    ew = 16'(wd >> (16 * (3 - (k - 6) / 4)));
                    chk($sformatf("c%0d_wr_addr", k), mem_addr, ea);
                    chk($sformatf("c%0d_wr_data", k), mem_wdata, ew);
                    mem[ea] = ew;
                end
            end else if (k == ncyc) begin
                chk("desel_rd", 16'(mem_rd), 16'h0);
                chk("desel_wr", 16'(mem_wr), 16'h0);
            end else begin
                chk("idle_oe", 16'(sio_oe), 16'h0);
                chk("idle_sio", 16'(sio_out), 16'h0);
                chk("idle_rd", 16'(mem_rd), 16'h0);
                chk("idle_wr", 16'(mem_wr), 16'h0);
            end
            if (k == rst_at) begin
                #2;
                rst_n = 1'b0;
                cs_n  = 1'b1;
                #1;
                chk_all_zero("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [15:0] a;
        int          sel;
        rst_n  = 1'b0;
        cs_n   = 1'b1;
        sio_in = 4'h0;
        mem_rdata = 16'h0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic read with streaming into a second word
        mem[16'h1234] = 16'hABCD;
        mem[16'h1235] = 16'($urandom);
        mem[16'h1236] = 16'($urandom);
        run_txn(8'h03, 16'h1234, 64'h0, 16, -1);

        // Read streaming across the top of the address space
        mem[16'hFFFF] = 16'h1111;
        mem[16'h0000] = 16'h2222;
        mem[16'h0001] = 16'($urandom);
        run_txn(8'h03, 16'hFFFF, 64'h0, 16, -1);

        // Two-word write, then read it back
        run_txn(8'h02, 16'h0010, 64'hBEEF_CAFE_0000_0000, 14, -1);
        mem[16'h0012] = 16'($urandom);
        run_txn(8'h03, 16'h0010, 64'h0, 16, -1);

        // Partial write word is discarded; a following read is unaffected
        run_txn(8'h02, 16'h0400, {32'($urandom), 32'($urandom)}, 8, -1);
        run_txn(8'h03, 16'h1234, 64'h0, 12, -1);

        // Unknown command is ignored
        run_txn(8'h9F, 16'h1234, 64'h0, 14, -1);
        run_txn(8'h03, 16'h1234, 64'h0, 12, -1);

        // Deselect exactly on a scheduled read prefetch and write strobe
        run_txn(8'h03, 16'h1234, 64'h0, 10, -1);
        run_txn(8'h02, 16'h0200, {32'($urandom), 32'($urandom)}, 9, -1);

        // Asynchronous reset during read data, then a clean read
        run_txn(8'h03, 16'h1234, 64'h0, 16, 9);
        run_txn(8'h03, 16'h1234, 64'h0, 12, -1);

        // Randomized mix of reads, writes and unknown commands
        for (int t = 0; t < 24; t++) begin
            sel = int'($urandom_range(0, 2));
            a   = (t % 5 == 0) ? 16'hFFFE : 16'($urandom);
            if (sel == 0)      cmd = 8'h03;
            else if (sel == 1) cmd = 8'h02;
            else begin
                cmd = 8'($urandom);
                if (cmd == 8'h02 || cmd == 8'h03) cmd = 8'hA5;
            end
            if (sel == 0) begin
                for (int j = 0; j < 5; j++) mem[16'(int'(a) + j)] = 16'($urandom);
            end
            run_txn(cmd, a, {32'($urandom), 32'($urandom)}, int'($urandom_range(1, 22)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
